// File: rtl/alu_seq_unit_if.sv
// Operand/result bundle between the control unit and the multi-cycle ALU.
// The control unit drives the master side; the ALU implements the slave side.
interface alu_seq_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       func_select;
    logic [WIDTH-1:0] x_bus;
    logic [WIDTH-1:0] y_bus;
    logic [WIDTH-1:0] z_bus;
    logic             Zin;
    logic             Vin;
    logic             Sin;
    logic             Cin;
    logic             busy;
    logic             done;

    modport master (
        output start, func_select, x_bus, y_bus,
        input  z_bus, Zin, Vin, Sin, Cin, busy, done
    );

    modport slave (
        input  start, func_select, x_bus, y_bus,
        output z_bus, Zin, Vin, Sin, Cin, busy, done
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU with registered result/flags and start/busy/done handshake.
// Define ALU_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 111.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_unit_if.slave    bus
);
    logic [WIDTH-1:0] x, y;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zf_q, zf_d;
    logic             vf_q, vf_d;
    logic             sf_q, sf_d;
    logic             cf_q, cf_d;
    logic             done_q, done_d;
    logic             busy;
    logic             accept;
    logic             op_go;

    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] res;
    logic             c_op, v_op, wr_flags;

    assign x      = bus.x_bus;
    assign y      = bus.y_bus;
    assign accept = bus.start & ~busy;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic               mul_go;

    assign busy     = (state_q == S_MUL);
    assign mul_go   = accept & (bus.func_select == 3'b111);
    assign op_go    = accept & ~mul_go;
    assign acc_step = acc_q + (mp_q[0] ? mc_q : '0);
`else
    assign busy  = 1'b0;
    assign op_go = accept;
`endif

    always_comb begin
        add_w    = {1'b0, x} + {1'b0, y};
        sub_w    = {1'b0, x} - {1'b0, y};
        res      = '0;
        c_op     = 1'b0;
        v_op     = 1'b0;
        wr_flags = 1'b1;
        unique case (bus.func_select)
            3'b000: begin
                res  = add_w[WIDTH-1:0];
                c_op = add_w[WIDTH];
                v_op = (x[WIDTH-1] == y[WIDTH-1]) &&
                       (add_w[WIDTH-1] != x[WIDTH-1]);
            end
            3'b001: begin
                res  = sub_w[WIDTH-1:0];
                c_op = sub_w[WIDTH];
                v_op = (x[WIDTH-1] != y[WIDTH-1]) &&
                       (sub_w[WIDTH-1] != x[WIDTH-1]);
            end
            3'b010: res = x & y;
            3'b011: res = x | y;
            3'b100: res = x ^ y;
            3'b101: begin
                res  = {x[WIDTH-2:0], 1'b0};
                c_op = x[WIDTH-1];
                v_op = x[WIDTH-1] ^ x[WIDTH-2];
            end
            3'b110: begin
                res  = {x[WIDTH-1], x[WIDTH-1:1]};
                c_op = x[0];
            end
            3'b111: begin
                // Only reached without the multiplier: zero result, flags kept.
                res      = '0;
                wr_flags = 1'b0;
            end
        endcase
    end

    always_comb begin
        z_d    = z_q;
        zf_d   = zf_q;
        vf_d   = vf_q;
        sf_d   = sf_q;
        cf_d   = cf_q;
        done_d = 1'b0;
`ifdef ALU_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (mul_go) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mc_d    = {{WIDTH{1'b0}}, x};
                    mp_d    = y;
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    z_d     = acc_step[WIDTH-1:0];
                    zf_d    = (acc_step[WIDTH-1:0] == '0);
                    sf_d    = acc_step[WIDTH-1];
                    cf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    vf_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
`endif
        if (op_go) begin
            z_d    = res;
            done_d = 1'b1;
            if (wr_flags) begin
                zf_d = (res == '0);
                sf_d = res[WIDTH-1];
                cf_d = c_op;
                vf_d = v_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q     <= '0;
            zf_q    <= 1'b0;
            vf_q    <= 1'b0;
            sf_q    <= 1'b0;
            cf_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_MUL_EN
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
`endif
        end else begin
            z_q     <= z_d;
            zf_q    <= zf_d;
            vf_q    <= vf_d;
            sf_q    <= sf_d;
            cf_q    <= cf_d;
            done_q  <= done_d;
`ifdef ALU_MUL_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign bus.z_bus = z_q;
    assign bus.Zin   = zf_q;
    assign bus.Vin   = vf_q;
    assign bus.Sin   = sf_q;
    assign bus.Cin   = cf_q;
    assign bus.busy  = busy;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=16.
// Multiplier vectors are built only when ALU_MUL_EN is defined.
module tb_alu_seq_unit;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_seq_unit_if #(.WIDTH(16)) alu_if ();

    alu_seq_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (alu_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flags packed as {Z,V,S,C}
    task automatic chk_out(input string tag, input logic [15:0] z,
                           input logic [3:0] f, input logic dn);
        chk({tag, ".z"}, 64'(alu_if.z_bus), 64'(z));
        chk({tag, ".zvsc"}, 64'({alu_if.Zin, alu_if.Vin,
                                 alu_if.Sin, alu_if.Cin}), 64'(f));
        chk({tag, ".done"}, 64'(alu_if.done), 64'(dn));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [15:0] xv,
                         input logic [15:0] yv);
        alu_if.start       = 1'b1;
        alu_if.func_select = f;
        alu_if.x_bus       = xv;
        alu_if.y_bus       = yv;
        @(negedge clk);
    endtask

    task automatic op(input string tag, input logic [2:0] f,
                      input logic [15:0] xv, input logic [15:0] yv,
                      input logic [15:0] z, input logic [3:0] fl);
        issue(f, xv, yv);
        alu_if.start = 1'b0;
        chk_out(tag, z, fl, 1'b1);
        chk({tag, ".busy"}, 64'(alu_if.busy), 64'(0));
    endtask

`ifdef ALU_MUL_EN
    // Waits for done; pulses a stray start in busy cycle 3.
    task automatic wait_mul(input string tag, output int nb);
        int n;
        nb = 0;
        n  = 0;
        while (!alu_if.done && n < 40) begin
            if (alu_if.busy) nb++;
            alu_if.start = (nb == 3 && alu_if.busy);
            if (alu_if.start) begin
                alu_if.func_select = 3'b000;
                alu_if.x_bus       = 16'h0001;
                alu_if.y_bus       = 16'h0001;
            end
            @(negedge clk);
            n++;
        end
        alu_if.start = 1'b0;
        chk({tag, ".timeout"}, 64'(n < 40), 64'(1));
    endtask
`endif

    initial begin
`ifdef ALU_MUL_EN
        int nb;
`endif
        rst                = 1'b1;
        alu_if.start       = 1'b0;
        alu_if.func_select = 3'b000;
        alu_if.x_bus       = '0;
        alu_if.y_bus       = '0;
        repeat (3) @(negedge clk);
        chk_out("reset", 16'h0000, 4'b0000, 1'b0);
        chk("reset.busy", 64'(alu_if.busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        op("add_ov", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110);
        @(negedge clk);
        chk("hold.done", 64'(alu_if.done), 64'(0));
        chk("hold.z", 64'(alu_if.z_bus), 64'(16'h8000));

        op("sub_brw", 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0011);
        op("and_z", 3'b010, 16'h0F0F, 16'hF0F0, 16'h0000, 4'b1000);

        // back-to-back accepts on consecutive edges
        issue(3'b011, 16'h0F0F, 16'hF0F0);
        chk_out("or_b2b", 16'hFFFF, 4'b0010, 1'b1);
        issue(3'b100, 16'h1234, 16'hFFFF);
        chk_out("xor_b2b", 16'hEDCB, 4'b0010, 1'b1);
        alu_if.start = 1'b0;

        op("shl_v", 3'b101, 16'h4000, 16'h0000, 16'h8000, 4'b0110);
        op("shr_c", 3'b110, 16'h8001, 16'h0000, 16'hC000, 4'b0011);
        op("sub_ov", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100);
        op("add_cz", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001);

`ifdef ALU_MUL_EN
        issue(3'b111, 16'h0123, 16'h0010);
        alu_if.start = 1'b0;
        wait_mul("mul1", nb);
        chk("mul1.nbusy", 64'(nb), 64'(16));
        chk("mul1.busy", 64'(alu_if.busy), 64'(0));
        chk_out("mul1", 16'h1230, 4'b0000, 1'b1);
        @(negedge clk);
        chk("mul1.nodup", 64'(alu_if.done), 64'(0));

        issue(3'b111, 16'h8000, 16'h0002);
        alu_if.start = 1'b0;
        wait_mul("mul2", nb);
        chk_out("mul2", 16'h0000, 4'b1001, 1'b1);
        // accepted in the done cycle
        op("shl_after", 3'b101, 16'h4000, 16'h0000, 16'h8000, 4'b0110);

        issue(3'b111, 16'h0005, 16'h0007);
        alu_if.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.busy5", 64'(alu_if.busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out("abort", 16'h0000, 4'b0000, 1'b0);
        chk("abort.busy", 64'(alu_if.busy), 64'(0));
        repeat (20) begin
            @(negedge clk);
            chk("abort.nodone", 64'(alu_if.done), 64'(0));
        end
`else
        op("mul_off", 3'b111, 16'h1234, 16'h5678, 16'h0000, 4'b1001);
        @(negedge clk);
        chk("mul_off.busy", 64'(alu_if.busy), 64'(0));
        chk("mul_off.nodup", 64'(alu_if.done), 64'(0));
        op("mul_off2", 3'b111, 16'h0003, 16'h0003, 16'h0000, 4'b1001);
`endif

        // rst and start together: request dropped
        op("pre_rst", 3'b011, 16'h00F0, 16'h0000, 16'h00F0, 4'b0000);
        rst = 1'b1;
        issue(3'b000, 16'h0001, 16'h0001);
        alu_if.start = 1'b0;
        rst          = 1'b0;
        chk_out("rst_win", 16'h0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("rst_win.done", 64'(alu_if.done), 64'(0));

        op("add_23", 3'b000, 16'h0002, 16'h0003, 16'h0005, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
